// File: rtl/mbist_march_controller.sv
// March C- sequencer for the MBIST collar: drives address-counter load/step, read/write strobes and
// the data background, and accumulates comparator fails over N_PASS repetitions of the test.
module mbist_march_controller #(
  parameter int N_PASS        = 1,
  parameter int ABORT_ON_FAIL = 0,
  parameter int FAIL_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cout,
  input  logic                  fail_in,
  output logic                  NbarT,
  output logic                  ld,
  output logic                  up_dn,
  output logic                  cnt_en,
  output logic                  rd_en,
  output logic                  wr_en,
  output logic                  wr_data,
  output logic [2:0]            elem_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [FAIL_CNT_W-1:0] fail_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_OP0, S_OP1, S_NEXT, S_DONE} state_t;

  localparam logic [7:0] LAST_PASS = 8'(N_PASS - 1);
  localparam logic [2:0] LAST_ELEM = 3'd5;

  state_t                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic [7:0]            pass_q, pass_d;
  logic                  fail_q;
  logic [FAIL_CNT_W-1:0] fail_cnt_q;
  logic                  clr_flags;

  // March C- element table: elements 0..2 ascend, 3..5 descend
  function automatic logic elem_up(input logic [2:0] e);
    return (e < 3'd3);
  endfunction

  function automatic logic elem_two_ops(input logic [2:0] e);
    return (e >= 3'd1) && (e <= 3'd4);
  endfunction

  function automatic logic op0_is_read(input logic [2:0] e);
    return (e != 3'd0);
  endfunction

  function automatic logic op0_value(input logic [2:0] e);
    return (e == 3'd2) || (e == 3'd4);
  endfunction

  function automatic logic op1_value(input logic [2:0] e);
    return (e == 3'd1) || (e == 3'd3);
  endfunction

  function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    pass_d    = pass_q;
    clr_flags = 1'b0;
    NbarT     = 1'b0;
    ld        = 1'b0;
    up_dn     = 1'b1;
    cnt_en    = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          state_d   = S_LOAD;
          elem_d    = 3'd0;
          pass_d    = 8'd0;
          clr_flags = 1'b1;
        end
      end
      S_LOAD: begin
        NbarT   = 1'b1;
        busy    = 1'b1;
        ld      = 1'b1;
        up_dn   = elem_up(elem_q);
        state_d = S_OP0;
      end
      S_OP0: begin
        NbarT   = 1'b1;
        busy    = 1'b1;
        up_dn   = elem_up(elem_q);
        rd_en   = op0_is_read(elem_q);
        wr_en   = !op0_is_read(elem_q);
        wr_data = op0_value(elem_q);
        state_d = elem_two_ops(elem_q) ? S_OP1 : S_NEXT;
      end
      S_OP1: begin
        NbarT   = 1'b1;
        busy    = 1'b1;
        up_dn   = elem_up(elem_q);
        wr_en   = 1'b1;
        wr_data = op1_value(elem_q);
        state_d = S_NEXT;
      end
      S_NEXT: begin
        NbarT = 1'b1;
        busy  = 1'b1;
        up_dn = elem_up(elem_q);
        if (!cout) begin
          cnt_en  = 1'b1;
          state_d = S_OP0;
        end else if (elem_q < LAST_ELEM) begin
          elem_d  = elem_q + 3'd1;
          state_d = S_LOAD;
        end else if (pass_q < LAST_PASS) begin
          pass_d  = pass_q + 8'd1;
          elem_d  = 3'd0;
          state_d = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A failing read ends the test immediately when aborting is enabled
    if ((ABORT_ON_FAIL != 0) && rd_en && fail_in) begin
      state_d = S_DONE;
    end
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      elem_q     <= 3'd0;
      pass_q     <= 8'd0;
      fail_q     <= 1'b0;
      fail_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      pass_q  <= pass_d;
      if (clr_flags) begin
        fail_q     <= 1'b0;
        fail_cnt_q <= '0;
      end else if (rd_en && fail_in) begin
        fail_q     <= 1'b1;
        fail_cnt_q <= sat_inc(fail_cnt_q);
      end
    end
  end

  assign elem_idx = elem_q;
  assign fail     = fail_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_mbist_march_controller.sv
// Directed bench: three controllers (default, abort-on-fail, three passes) each on a 4-address counter model.
module tb_mbist_march_controller;

  logic       clk;
  logic       rst;
  logic [2:0] start;
  logic [2:0] cout;
  logic [2:0] fin;
  logic [2:0] nbart, ld, up, cnt, rd, wr, wd, busy, done, fail;
  logic [2:0] elem [3];
  logic [7:0] fcnt [3];
  logic [1:0] addr [3];
  logic [31:0] mask [3];

  int ncmp = 0;
  int nfail = 0;

  logic at0_ld, at0_nbart, at0_fail;
  logic [7:0] at0_fcnt;
  logic e3_updn;
  int   e3_first_addr;
  int   e1n;
  int   e1code [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mbist_march_controller #(
      .N_PASS       ((g == 2) ? 3 : 1),
      .ABORT_ON_FAIL((g == 1) ? 1 : 0),
      .FAIL_CNT_W   (8)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start[g]),
      .cout    (cout[g]),
      .fail_in (fin[g]),
      .NbarT   (nbart[g]),
      .ld      (ld[g]),
      .up_dn   (up[g]),
      .cnt_en  (cnt[g]),
      .rd_en   (rd[g]),
      .wr_en   (wr[g]),
      .wr_data (wd[g]),
      .elem_idx(elem[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .fail    (fail[g]),
      .fail_cnt(fcnt[g])
    );
  end

  // 4-address counter model, 0..3
  always_ff @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (ld[g]) addr[g] <= up[g] ? 2'd0 : 2'd3;
      else if (cnt[g]) addr[g] <= up[g] ? addr[g] + 2'd1 : addr[g] - 2'd1;
    end
  end

  always_comb begin
    cout = '0;
    fin  = '0;
    for (int g = 0; g < 3; g++) begin
      cout[g] = up[g] ? (addr[g] == 2'd3) : (addr[g] == 2'd0);
      fin[g]  = rd[g] & mask[g][{elem[g], addr[g]}];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start, then follow the run cycle by cycle until done (or a reset request in elem 3 OP1)
  task automatic run(input int g, input int maxc, input int midstart_k, input bit rst_e3,
                     output int tdone, output int nwr, output int nrd, output int wraps);
    int prev_elem;
    tdone = -1; nwr = 0; nrd = 0; wraps = 0; prev_elem = 0;
    e3_updn = 1'b1; e3_first_addr = -1; e1n = 0; e1code[0] = -1; e1code[1] = -1;
    start[g] = 1'b1;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start[g]  = 1'b0;
        at0_ld    = ld[g];
        at0_nbart = nbart[g];
        at0_fail  = fail[g];
        at0_fcnt  = fcnt[g];
      end
      if (k == midstart_k) start[g] = 1'b1;
      if (k == midstart_k + 1) start[g] = 1'b0;
      if (done[g]) begin
        tdone = k;
        break;
      end
      if (wr[g]) nwr++;
      if (rd[g]) nrd++;
      if (ld[g] && elem[g] == 3'd3) e3_updn = up[g];
      if (rd[g] && elem[g] == 3'd3 && e3_first_addr < 0) e3_first_addr = int'(addr[g]);
      if (elem[g] == 3'd1 && (rd[g] || wr[g]) && e1n < 2) begin
        e1code[e1n] = int'({rd[g], wr[g], wd[g]});
        e1n++;
      end
      if (k > 0 && prev_elem == 5 && elem[g] == 3'd0) wraps++;
      prev_elem = int'(elem[g]);
      if (rst_e3 && wr[g] && elem[g] == 3'd3) begin
        rst   = 1'b1;
        tdone = k;
        break;
      end
    end
  endtask

  initial begin
    int td, nw, nr, wp, post;
    rst   = 1'b1;
    start = '0;
    for (int g = 0; g < 3; g++) mask[g] = '0;
    repeat (3) @(negedge clk);

    // Reset state: everything low except up_dn
    check("reset_outputs", {22'd0, nbart[0], ld[0], up[0], cnt[0], rd[0], wr[0], wd[0], busy[0], done[0], fail[0]},
          32'b0010000000);
    check("reset_elem", elem[0], 0);
    check("reset_fail_cnt", fcnt[0], 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_nbart", nbart[0], 0);

    // Clean single pass; a start pulse while busy must not disturb it
    run(0, 200, 30, 1'b0, td, nw, nr, wp);
    check("a_first_load_ld", at0_ld, 1);
    check("a_first_load_nbart", at0_nbart, 1);
    check("a_done_cycle", td, 70);
    check("a_wr_count", nw, 20);
    check("a_rd_count", nr, 20);
    check("a_fail", fail[0], 0);
    check("a_fail_cnt", fcnt[0], 0);
    check("a_done_nbart", nbart[0], 0);
    check("a_done_busy", busy[0], 0);
    check("a_e3_load_updn", e3_updn, 0);
    check("a_e3_first_read_addr", e3_first_addr, 3);
    check("a_e1_addr0_op0_r0", e1code[0], 3'b100);
    check("a_e1_addr0_op1_w1", e1code[1], 3'b011);

    // Two injected fails without abort: run length unchanged
    mask[0] = (32'd1 << 9) | (32'd1 << 16);
    run(0, 200, -1, 1'b0, td, nw, nr, wp);
    check("b_done_cycle", td, 70);
    check("b_fail", fail[0], 1);
    check("b_fail_cnt", fcnt[0], 2);
    @(negedge clk);
    check("b_done_hold_fail_cnt", fcnt[0], 2);

    // Restart from DONE clears flags; then reset in elem 3 OP1
    mask[0] = '0;
    run(0, 200, -1, 1'b1, td, nw, nr, wp);
    check("c_restart_fail_clr", at0_fail, 0);
    check("c_restart_fcnt_clr", at0_fcnt, 0);
    check("c_rst_reached", (td >= 0) ? 1 : 0, 1);
    @(negedge clk);
    check("c_rst_nbart", nbart[0], 0);
    check("c_rst_busy", busy[0], 0);
    check("c_rst_elem", elem[0], 0);
    check("c_rst_fail_cnt", fcnt[0], 0);
    rst = 1'b0;
    @(negedge clk);

    // Abort on the first read of elem 1 (address 0)
    mask[1] = 32'd1 << 4;
    run(1, 50, -1, 1'b0, td, nw, nr, wp);
    check("d_done_cycle", td, 11);
    check("d_wr_count", nw, 4);
    check("d_rd_count", nr, 1);
    check("d_elem", elem[1], 1);
    check("d_fail", fail[1], 1);
    check("d_fail_cnt", fcnt[1], 1);
    post = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rd[1] || wr[1] || ld[1] || cnt[1]) post++;
    end
    check("d_no_strobes_after", post, 0);
    check("d_still_done", done[1], 1);

    // Three passes
    run(2, 400, -1, 1'b0, td, nw, nr, wp);
    check("e_done_cycle", td, 210);
    check("e_wr_count", nw, 60);
    check("e_rd_count", nr, 60);
    check("e_elem_wraps", wp, 2);
    check("e_fail", fail[2], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mbist_march_controller.md
Name: mbist_march_controller

Overview:
- Parametrised successor to the single-mode BIST controller.
- Sequences a complete March C- test over an external address counter. It drives per-element counter load and direction, read/write strobes and the data background.
- Collects the comparator fail indication into a sticky flag and a saturating count. Repeats the test N_PASS times, with optional abort on first fail.
- Sits between the MBIST top-level start/status interface and the memory collar (address counter, data generator, comparator).

Parameters:
- N_PASS, 1, number of complete March C- passes per start (1..255).
- ABORT_ON_FAIL, 0, 1 = go to DONE on the first fail; 0 = run all passes.
- FAIL_CNT_W, 8, width of the saturating fail counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; sampled in IDLE and DONE only.
- cout  in  1  address counter at terminal value (max when counting up, 0 when counting down).
- fail_in  in  1  comparator mismatch; meaningful only in cycles with rd_en=1.
- NbarT  out  1  1 = test mode (mux selects BIST), 0 = normal mode.
- ld  out  1  one-cycle pulse: counter loads 0 if up_dn=1, max if up_dn=0.
- up_dn  out  1  counter direction for the current element (1 = up).
- cnt_en  out  1  counter steps one address at the next edge.
- rd_en  out  1  memory read strobe.
- wr_en  out  1  memory write strobe.
- wr_data  out  1  data background, expanded to full word by the datapath; also the expected read value.
- elem_idx  out  3  current march element, 0..5.
- busy  out  1  high in LOAD/OP0/OP1/NEXT.
- done  out  1  high in DONE.
- fail  out  1  sticky fail flag.
- fail_cnt  out  FAIL_CNT_W  saturating count of failing reads.

Behaviour:
- Reset (synchronous, any state including mid-test) leaves the block in IDLE with:
  - all outputs 0 except up_dn=1;
  - elem_idx=0, pass counter=0, fail=0, fail_cnt=0.
- Element table (elem: direction, ops):
  - 0: up, w0
  - 1: up, r0 w1
  - 2: up, r1 w0
  - 3: down, r0 w1
  - 4: down, r1 w0
  - 5: down, r0
  - For a read, wr_data carries the expected value.
- IDLE: NbarT=0. start=1 → LOAD with elem_idx=0 and pass counter=0. Entry from IDLE or DONE clears fail and fail_cnt.
- LOAD: NbarT=1, ld=1, up_dn=table direction → OP0.
- OP0: first op of the element (rd_en or wr_en, wr_data=op value).
  - Two-op element → OP1.
  - Otherwise → NEXT.
- OP1: second op → NEXT.
- NEXT: no memory strobe.
  - cout=0: cnt_en=1 → OP0.
  - cout=1 and elem_idx<5: elem_idx+1 → LOAD.
  - cout=1 and elem_idx=5 and pass<N_PASS-1: pass+1, elem_idx=0 → LOAD.
  - Otherwise → DONE.
- DONE: NbarT=0, done=1; fail and fail_cnt hold. start=1 → LOAD (restart, flags cleared); start=0 → stay.
- start while busy is ignored. A start held high through DONE restarts immediately, so the top level pulses start.
- Fail capture: in any cycle with rd_en=1 and fail_in=1:
  - fail←1 at the next edge;
  - fail_cnt+1, saturating at all-ones.
  - If ABORT_ON_FAIL=1, the next state is DONE regardless of the state table, and the counter is not stepped.
- Timing per pass, for A addresses: 6 + A×16 cycles from first LOAD to DONE entry (each address costs op count + 1; each element costs 1 LOAD).
- Strobe counts per pass: wr_en = 5A pulses, rd_en = 5A pulses.
- ld and cnt_en are never high together. rd_en and wr_en are never high together.

Test Plan:
- Reset, then start pulse, with a 4-address counter model and N_PASS=1 → NbarT rises with the first LOAD; done rises 70 cycles after the first LOAD; 20 wr_en and 20 rd_en pulses; fail=0; fail_cnt=0; NbarT=0 in DONE.
- Same run, check per-element strobe order and up_dn:
  - elem 3 starts with ld=1, up_dn=0;
  - the first address read is 3;
  - wr_data sequence for elem 1 at addr 0 is r0 then w1.
- fail_in=1 on two rd_en cycles (elem 2 addr 1, elem 4 addr 0), ABORT_ON_FAIL=0 → fail=1; fail_cnt=2; done still at cycle 70.
- ABORT_ON_FAIL=1, fail_in on the first read of elem 1 → DONE the next cycle; elem_idx=1; fail_cnt=1; no further strobes.
- N_PASS=3, 4 addresses → done after 210 cycles; 60 wr_en pulses; elem_idx wraps 5→0 twice.
- rst asserted in elem 3 OP1 → next cycle IDLE with NbarT=0, busy=0, elem_idx=0. A start asserted during busy has no effect. A start in DONE restarts with fail cleared.
